// File: rtl/xbar_alloc.sv
// Switch allocator for a 5x5 router crossbar.
// Round-robin arbitration per output, with a per-output lock that holds one
// input on an output for the whole of a multi-flit packet. Grants, selects
// and output valids are combinational. Pointers, locks and err are registered.
module xbar_alloc #(
    parameter int NPORT = 5,
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NPORT-1:0] req_valid,
    input  logic [SEL_W-1:0] req_port0,
    input  logic [SEL_W-1:0] req_port1,
    input  logic [SEL_W-1:0] req_port2,
    input  logic [SEL_W-1:0] req_port3,
    input  logic [SEL_W-1:0] req_port4,
    input  logic [NPORT-1:0] req_last,
    input  logic [NPORT-1:0] out_ready,
    output logic [NPORT-1:0] gnt,
    output logic [SEL_W-1:0] ctl0,
    output logic [SEL_W-1:0] ctl1,
    output logic [SEL_W-1:0] ctl2,
    output logic [SEL_W-1:0] ctl3,
    output logic [SEL_W-1:0] ctl4,
    output logic [NPORT-1:0] ovalid,
    output logic [NPORT-1:0] lock_busy,
    output logic             err
);

    logic [SEL_W-1:0] req_port [NPORT];
    logic [NPORT-1:0] win_vec;
    logic [SEL_W-1:0] win_id_arr [NPORT];
    logic [NPORT-1:0] illegal;
    logic             err_reg;

    assign req_port[0] = req_port0;
    assign req_port[1] = req_port1;
    assign req_port[2] = req_port2;
    assign req_port[3] = req_port3;
    assign req_port[4] = req_port4;

    // Modulo-NPORT increment of an input index (base is always 0..NPORT-1).
    function automatic logic [SEL_W-1:0] wrap_add(input logic [SEL_W-1:0] base, input int step);
        int sum;
        sum = int'(base) + step;
        if (sum >= NPORT) sum = sum - NPORT;
        return SEL_W'(sum);
    endfunction

    genvar gi;

    // One arbiter plus its pointer/lock state per output.
    generate
        for (gi = 0; gi < NPORT; gi++) begin : g_out
            logic [NPORT-1:0] cand;
            logic             scan_hit;
            logic [SEL_W-1:0] scan_id;
            logic             win;
            logic [SEL_W-1:0] win_id;
            logic [SEL_W-1:0] ptr_reg, ptr_next;
            logic             lock_v_reg, lock_v_next;
            logic [SEL_W-1:0] lock_id_reg, lock_id_next;

            // Inputs presenting a legal flit addressed to this output.
            always_comb begin
                cand = '0;
                for (int i = 0; i < NPORT; i++) begin
                    cand[i] = req_valid[i] && (req_port[i] == SEL_W'(gi));
                end
            end

            // Round-robin scan starting at the pointer.
            always_comb begin
                scan_hit = 1'b0;
                scan_id  = '0;
                for (int k = 0; k < NPORT; k++) begin
                    if (!scan_hit && cand[wrap_add(ptr_reg, k)]) begin
                        scan_hit = 1'b1;
                        scan_id  = wrap_add(ptr_reg, k);
                    end
                end
            end

            // Winner selection: lock holder only when locked, else the scan result.
            always_comb begin
                win    = 1'b0;
                win_id = '0;
                if (!rst && out_ready[gi]) begin
                    if (lock_v_reg) begin
                        if (cand[lock_id_reg]) begin
                            win    = 1'b1;
                            win_id = lock_id_reg;
                        end
                    end else if (scan_hit) begin
                        win    = 1'b1;
                        win_id = scan_id;
                    end
                end
            end

            // Pointer advances past the winner; a non-tail flit (re)takes the lock.
            always_comb begin
                ptr_next     = ptr_reg;
                lock_v_next  = lock_v_reg;
                lock_id_next = lock_id_reg;
                if (win) begin
                    ptr_next = (win_id == SEL_W'(NPORT - 1)) ? '0 : win_id + SEL_W'(1);
                    if (req_last[win_id]) begin
                        lock_v_next = 1'b0;
                    end else begin
                        lock_v_next  = 1'b1;
                        lock_id_next = win_id;
                    end
                end
            end

            // Per-output state register.
            always_ff @(posedge clk) begin
                if (rst) begin
                    ptr_reg     <= '0;
                    lock_v_reg  <= 1'b0;
                    lock_id_reg <= '0;
                end else begin
                    ptr_reg     <= ptr_next;
                    lock_v_reg  <= lock_v_next;
                    lock_id_reg <= lock_id_next;
                end
            end

            assign win_vec[gi]    = win;
            assign win_id_arr[gi] = win_id;
            assign lock_busy[gi]  = lock_v_reg & ~rst;
        end
    endgenerate

    // Per-input grant collection and illegal-port detection.
    generate
        for (gi = 0; gi < NPORT; gi++) begin : g_in
            logic hit;

            // An input is granted if any output picked it.
            always_comb begin
                hit = 1'b0;
                for (int o = 0; o < NPORT; o++) begin
                    if (win_vec[o] && (win_id_arr[o] == SEL_W'(gi))) hit = 1'b1;
                end
            end

            assign gnt[gi]     = hit;
            assign illegal[gi] = req_valid[gi] && (req_port[gi] >= SEL_W'(NPORT));
        end
    endgenerate

    // Sticky error on any valid request to a non-existent output.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_reg <= 1'b0;
        end else if (|illegal) begin
            err_reg <= 1'b1;
        end
    end

    assign err    = err_reg;
    assign ovalid = win_vec;
    assign ctl0   = win_id_arr[0];
    assign ctl1   = win_id_arr[1];
    assign ctl2   = win_id_arr[2];
    assign ctl3   = win_id_arr[3];
    assign ctl4   = win_id_arr[4];

endmodule

// File: tb/tb_xbar_alloc.sv
// Directed self-checking bench for xbar_alloc.
module tb_xbar_alloc;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] req_valid;
    logic [4:0] req_last;
    logic [4:0] out_ready;
    logic [2:0] rp [5];
    logic [4:0] gnt;
    logic [2:0] ctl [5];
    logic [4:0] ovalid;
    logic [4:0] lock_busy;
    logic       err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    xbar_alloc dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_port0 (rp[0]),
        .req_port1 (rp[1]),
        .req_port2 (rp[2]),
        .req_port3 (rp[3]),
        .req_port4 (rp[4]),
        .req_last  (req_last),
        .out_ready (out_ready),
        .gnt       (gnt),
        .ctl0      (ctl[0]),
        .ctl1      (ctl[1]),
        .ctl2      (ctl[2]),
        .ctl3      (ctl[3]),
        .ctl4      (ctl[4]),
        .ovalid    (ovalid),
        .lock_busy (lock_busy),
        .err       (err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        req_valid = '0;
        req_last  = '0;
        out_ready = 5'h1F;
        for (int i = 0; i < 5; i++) rp[i] = 3'd0;
    endtask

    // Move to the sampling point of the current cycle and log it.
    task automatic sample(input string name);
        @(negedge clk);
        $display("%-10s t=%0t rst=%b v=%b ready=%b gnt=%b ovalid=%b ctl=%0d%0d%0d%0d%0d lock=%b err=%b",
                 name, $time, rst, req_valid, out_ready, gnt, ovalid,
                 ctl[0], ctl[1], ctl[2], ctl[3], ctl[4], lock_busy, err);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) rp[i] = 3'd2;
        req_valid = 5'h1F;
        req_last  = 5'h1F;

        // Reset: outputs forced low even with requests present
        sample("reset");
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_ovalid", 32'(ovalid), 32'h0);
        chk("rst_ctl2", 32'(ctl[2]), 32'h0);
        chk("rst_lock", 32'(lock_busy), 32'h0);
        next_cycle();
        next_cycle();
        chk("rst_err", 32'(err), 32'h0);
        rst = 1'b0;

        // Round robin at output 2: 0,1,2,3,4,0
        for (int c = 0; c < 6; c++) begin
            int w;
            w = c % 5;
            sample("rr");
            chk("rr_gnt", 32'(gnt), 32'd1 << w);
            chk("rr_ctl2", 32'(ctl[2]), 32'(w));
            chk("rr_ovalid", 32'(ovalid), 32'h04);
            next_cycle();
        end

        // Full permutation: input i -> output (i+1)%5
        for (int i = 0; i < 5; i++) rp[i] = 3'((i + 1) % 5);
        sample("perm");
        chk("perm_gnt", 32'(gnt), 32'h1F);
        chk("perm_ovalid", 32'(ovalid), 32'h1F);
        chk("perm_ctl0", 32'(ctl[0]), 32'd4);
        chk("perm_ctl1", 32'(ctl[1]), 32'd0);
        chk("perm_ctl2", 32'(ctl[2]), 32'd1);
        chk("perm_ctl3", 32'(ctl[3]), 32'd2);
        chk("perm_ctl4", 32'(ctl[4]), 32'd3);
        next_cycle();

        // Packet lock: input 3 sends 3 flits to output 1, input 0 contends
        idle();
        req_valid = 5'b01001;
        rp[0] = 3'd1;
        rp[3] = 3'd1;
        req_last = 5'b00001;
        for (int f = 0; f < 3; f++) begin
            req_last[3] = (f == 2);
            sample("lock");
            chk("lock_gnt", 32'(gnt), 32'h08);
            chk("lock_ctl1", 32'(ctl[1]), 32'd3);
            chk("lock_busy", 32'(lock_busy), (f == 0) ? 32'h00 : 32'h02);
            next_cycle();
        end
        req_valid = 5'b00001;
        sample("lock_end");
        chk("lock_end_gnt", 32'(gnt), 32'h01);
        chk("lock_end_ctl1", 32'(ctl[1]), 32'd0);
        chk("lock_end_busy", 32'(lock_busy), 32'h00);
        next_cycle();

        // Backpressure: input 2 locks output 4, ready drops for 2 cycles
        idle();
        req_valid = 5'b00100;
        rp[2] = 3'd4;
        sample("bp_head");
        chk("bp_head_gnt", 32'(gnt), 32'h04);
        chk("bp_head_ctl4", 32'(ctl[4]), 32'd2);
        next_cycle();
        req_valid = 5'b00110;
        rp[1] = 3'd4;
        req_last = 5'b00010;
        out_ready = 5'b01111;
        for (int s = 0; s < 2; s++) begin
            sample("bp_stall");
            chk("bp_stall_gnt", 32'(gnt), 32'h00);
            chk("bp_stall_ov4", 32'(ovalid[4]), 32'h0);
            chk("bp_stall_lock", 32'(lock_busy), 32'h10);
            next_cycle();
        end
        out_ready = 5'h1F;
        req_last  = 5'b00110;
        sample("bp_resume");
        chk("bp_resume_gnt", 32'(gnt), 32'h04);
        chk("bp_resume_ctl4", 32'(ctl[4]), 32'd2);
        next_cycle();
        req_valid = 5'b00010;
        sample("bp_other");
        chk("bp_other_gnt", 32'(gnt), 32'h02);
        chk("bp_other_lock", 32'(lock_busy), 32'h00);
        next_cycle();

        // Illegal port on input 1 alongside a legal request from input 0
        idle();
        req_valid = 5'b00011;
        rp[0] = 3'd3;
        rp[1] = 3'd6;
        req_last = 5'b00011;
        sample("illegal");
        chk("ill_gnt", 32'(gnt), 32'h01);
        chk("ill_ovalid", 32'(ovalid), 32'h08);
        chk("ill_err_now", 32'(err), 32'h0);
        next_cycle();
        sample("illegal2");
        chk("ill_err_next", 32'(err), 32'h1);
        chk("ill_gnt2", 32'(gnt), 32'h01);
        next_cycle();
        idle();
        sample("ill_sticky");
        chk("ill_err_sticky", 32'(err), 32'h1);
        next_cycle();

        // Reset mid-packet: input 4 holds output 0, then reset
        req_valid = 5'b10000;
        rp[4] = 3'd0;
        sample("mid_head");
        chk("mid_head_gnt", 32'(gnt), 32'h10);
        next_cycle();
        req_valid = 5'b10001;
        sample("mid_flit2");
        chk("mid_flit2_gnt", 32'(gnt), 32'h10);
        chk("mid_flit2_lock", 32'(lock_busy), 32'h01);
        next_cycle();
        rst = 1'b1;
        sample("mid_rst");
        chk("mid_rst_gnt", 32'(gnt), 32'h00);
        chk("mid_rst_ovalid", 32'(ovalid), 32'h00);
        chk("mid_rst_ctl0", 32'(ctl[0]), 32'd0);
        chk("mid_rst_lock", 32'(lock_busy), 32'h00);
        next_cycle();
        rst = 1'b0;
        sample("mid_after");
        chk("mid_after_gnt", 32'(gnt), 32'h01);
        chk("mid_after_ovalid", 32'(ovalid), 32'h01);
        chk("mid_after_lock", 32'(lock_busy), 32'h00);
        chk("mid_after_err", 32'(err), 32'h0);
        next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
